mprj2_power_sequencer: RTL and testbench
========================================

Name: mprj2_power_sequencer

Overview:
- Controller for the user-project domain 2 (vccd2/vssd2) enable path.
- Senses the domain's tie-high output (HI of the user-area logic-high cell; reads 0 when vccd2 is unpowered).
- On domain power-good plus a management request, sequences the domain in order: clock enable, reset release, then LA/IO enables. Powers down in reverse order.
- Sits in the management-protect region between the management SoC and user area 2.

Parameters:
- SYNC_STAGES, 2, flops in the hi_sense synchronizer (min 2).
- DEBOUNCE_CYCLES, 16, consecutive synchronized-high cycles required before power-up starts (min 1).
- STEP_DELAY, 4, wait cycles between sequence steps (min 1).
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, STEP_DELAY).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  asynchronous active-high reset.
- hi_sense  input  1  domain-2 tie-high sense; asynchronous to wb_clk_i.
- sw_enable  input  1  management request to power up (level).
- fault_clr  input  1  single-cycle pulse; clears the sticky fault.
- user2_clk_en  output  1  clock gate enable for domain 2.
- user2_rst_n  output  1  active-low reset to domain 2.
- user2_la_en  output  1  logic-analyzer path enable.
- user2_io_en  output  1  IO path enable.
- user2_powered  output  1  high only in state ON.
- user2_fault  output  1  sticky: domain power was lost while not OFF/DEBOUNCE.
- seq_state  output  3  current FSM state encoding (status readback).

Behaviour:
- Reset: all outputs 0, including user2_rst_n (domain held in reset). seq_state=OFF. Counter and synchronizer cleared. Outputs are asserted/deasserted asynchronously with wb_rst_i; release is synchronous.
- All outputs are registered. s = hi_sense after SYNC_STAGES flops.
- States: OFF, DEBOUNCE, CLK_ON, RST_REL, BUS_ON, ON, SD_BUS, SD_RST.
- OFF: if s & sw_enable & !user2_fault, go to DEBOUNCE with cnt=0.
- DEBOUNCE: if !s or !sw_enable, go to OFF. Else cnt++. When cnt==DEBOUNCE_CYCLES-1, go to CLK_ON, set clk_en=1 on the same edge, cnt=0.
- CLK_ON: after STEP_DELAY cycles, set rst_n=1 and go to RST_REL, cnt=0.
- RST_REL: after STEP_DELAY cycles, set la_en=io_en=1 and go to ON (BUS_ON is a one-cycle pass-through used only for encoding continuity). user2_powered rises on the same edge as la_en/io_en.
- ON: hold while s & sw_enable.
- Orderly shutdown when sw_enable=0 and s=1:
  - From ON: la/io=0 and powered=0 next edge, go to SD_BUS.
  - SD_BUS: after STEP_DELAY, rst_n=0, go to SD_RST.
  - SD_RST: after STEP_DELAY, clk_en=0, go to OFF.
  - From CLK_ON: go to SD_RST. From RST_REL: go to SD_BUS.
- sw_enable re-asserted during SD_*: shutdown completes to OFF first, then normal restart.
- Power loss (s=0) in any state other than OFF/DEBOUNCE: next edge forces all outputs 0, state=OFF, user2_fault=1. Power loss overrides sw_enable and overrides an in-progress shutdown.
- fault_clr clears user2_fault. A simultaneous fault set wins. While user2_fault=1 the FSM stays in OFF.
- Illegal state encoding: go to OFF with all outputs 0.
- Latency with defaults, measured from the hi_sense rise (sw_enable already high):
  - clk_en at edge 2+1+16 = 19.
  - rst_n at edge 23.
  - la_en/io_en/powered at edge 27.

Decomposition:
- Package mprj2_seq_pkg: state enum (3-bit encoding, OFF=0), default constants for DEBOUNCE_CYCLES and STEP_DELAY.
- Sub-module mprj2_sense_sync: SYNC_STAGES-deep reset-to-0 synchronizer for hi_sense.
- FSM and counter live in the top module.

Test Plan:
- Power-up: sw_enable=1, then hi_sense 0→1 at edge 0 → clk_en=1 at edge 19, rst_n=1 at edge 23, la_en=io_en=powered=1 at edge 27, seq_state=ON.
- Debounce glitch: hi_sense high for 10 cycles, low for 1, high again → no output changes. Full 19-edge count restarts from the re-rise.
- Orderly shutdown: in ON, drop sw_enable at edge E → la/io/powered=0 at E+1, rst_n=0 at E+5, clk_en=0 at E+9, seq_state=OFF.
- Power loss: in ON, hi_sense→0 → all outputs 0 within SYNC_STAGES+1 edges, user2_fault=1. FSM stays OFF despite sw_enable=1 until fault_clr pulses; then power-up restarts with the same 19/23/27 timing.
- Simultaneous: power loss on the same cycle as fault_clr → user2_fault stays 1.
- Async reset mid-sequence: in RST_REL, pulse wb_rst_i → all outputs 0 immediately (before the next clock edge), seq_state=OFF. After release, power-up repeats from the synchronizer.

Source files
------------

// File: rtl/mprj2_seq_pkg.sv
// rtl/mprj2_seq_pkg.sv - shared state encoding and default timing for the domain-2 power sequencer
package mprj2_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_CLK_ON   = 3'd2,
        ST_RST_REL  = 3'd3,
        ST_BUS_ON   = 3'd4,
        ST_ON       = 3'd5,
        ST_SD_BUS   = 3'd6,
        ST_SD_RST   = 3'd7
    } seq_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STEP_DELAY      = 4;

endpackage

// File: rtl/mprj2_sense_sync.sv
// rtl/mprj2_sense_sync.sv - reset-to-0 multi-flop synchronizer for the domain-2 tie-high sense
module mprj2_sense_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh <= '0;
        end else begin
            sh <= {sh[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sh[SYNC_STAGES-1];

endmodule

// File: rtl/mprj2_power_sequencer.sv
// rtl/mprj2_power_sequencer.sv - ordered power-up/down of user domain 2 gated by its tie-high sense
module mprj2_power_sequencer
    import mprj2_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_DELAY      = DEF_STEP_DELAY,
    parameter int CNT_W           = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       hi_sense,
    input  logic       sw_enable,
    input  logic       fault_clr,
    output logic       user2_clk_en,
    output logic       user2_rst_n,
    output logic       user2_la_en,
    output logic       user2_io_en,
    output logic       user2_powered,
    output logic       user2_fault,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DELAY - 1);

    seq_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s;
    logic             clk_en_nxt, rst_n_nxt, la_en_nxt, io_en_nxt, powered_nxt, fault_nxt;
    logic             lost;

    mprj2_sense_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (hi_sense),
        .q   (s)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= ST_OFF;
            cnt           <= '0;
            user2_clk_en  <= 1'b0;
            user2_rst_n   <= 1'b0;
            user2_la_en   <= 1'b0;
            user2_io_en   <= 1'b0;
            user2_powered <= 1'b0;
            user2_fault   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            user2_clk_en  <= clk_en_nxt;
            user2_rst_n   <= rst_n_nxt;
            user2_la_en   <= la_en_nxt;
            user2_io_en   <= io_en_nxt;
            user2_powered <= powered_nxt;
            user2_fault   <= fault_nxt;
        end
    end

    // Losing the sense rail anywhere past debounce is a fault; in OFF/DEBOUNCE it is just "not ready".
    assign lost = !s && (state != ST_OFF) && (state != ST_DEBOUNCE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        clk_en_nxt  = user2_clk_en;
        rst_n_nxt   = user2_rst_n;
        la_en_nxt   = user2_la_en;
        io_en_nxt   = user2_io_en;
        powered_nxt = user2_powered;
        fault_nxt   = user2_fault && !fault_clr;

        case (state)
            ST_OFF: begin
                if (s && sw_enable && !user2_fault) begin
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!s || !sw_enable) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = ST_CLK_ON;
                    clk_en_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CLK_ON: begin
                if (!sw_enable) begin
                    state_nxt = ST_SD_RST;
                    cnt_nxt   = '0;
                end else if (cnt == STEP_LAST) begin
                    state_nxt = ST_RST_REL;
                    rst_n_nxt = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RST_REL: begin
                if (!sw_enable) begin
                    state_nxt = ST_SD_BUS;
                    cnt_nxt   = '0;
                end else if (cnt == STEP_LAST) begin
                    state_nxt   = ST_ON;
                    la_en_nxt   = 1'b1;
                    io_en_nxt   = 1'b1;
                    powered_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_BUS_ON, ST_ON: begin
                if (!sw_enable) begin
                    state_nxt   = ST_SD_BUS;
                    la_en_nxt   = 1'b0;
                    io_en_nxt   = 1'b0;
                    powered_nxt = 1'b0;
                    cnt_nxt     = '0;
                end else begin
                    state_nxt   = ST_ON;
                    la_en_nxt   = 1'b1;
                    io_en_nxt   = 1'b1;
                    powered_nxt = 1'b1;
                end
            end
            ST_SD_BUS: begin
                if (cnt == STEP_LAST) begin
                    state_nxt = ST_SD_RST;
                    rst_n_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_SD_RST: begin
                if (cnt == STEP_LAST) begin
                    state_nxt  = ST_OFF;
                    clk_en_nxt = 1'b0;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = ST_OFF;
                cnt_nxt     = '0;
                clk_en_nxt  = 1'b0;
                rst_n_nxt   = 1'b0;
                la_en_nxt   = 1'b0;
                io_en_nxt   = 1'b0;
                powered_nxt = 1'b0;
            end
        endcase

        // Power loss beats everything, including a pending fault_clr.
        if (lost) begin
            state_nxt   = ST_OFF;
            cnt_nxt     = '0;
            clk_en_nxt  = 1'b0;
            rst_n_nxt   = 1'b0;
            la_en_nxt   = 1'b0;
            io_en_nxt   = 1'b0;
            powered_nxt = 1'b0;
            fault_nxt   = 1'b1;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_mprj2_power_sequencer.sv
// tb/tb_mprj2_power_sequencer.sv - directed self-checking bench for the domain-2 power sequencer
module tb_mprj2_power_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       hi_sense;
    logic       sw_enable;
    logic       fault_clr;
    logic       user2_clk_en, user2_rst_n, user2_la_en, user2_io_en, user2_powered, user2_fault;
    logic [2:0] seq_state;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    mprj2_power_sequencer dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .hi_sense      (hi_sense),
        .sw_enable     (sw_enable),
        .fault_clr     (fault_clr),
        .user2_clk_en  (user2_clk_en),
        .user2_rst_n   (user2_rst_n),
        .user2_la_en   (user2_la_en),
        .user2_io_en   (user2_io_en),
        .user2_powered (user2_powered),
        .user2_fault   (user2_fault),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    // Packs {clk_en, rst_n, la_en, io_en, powered, fault} for compact whole-output checks.
    function automatic logic [7:0] outs();
        return {2'b00, user2_clk_en, user2_rst_n, user2_la_en, user2_io_en, user2_powered, user2_fault};
    endfunction

    initial begin
        rst = 1'b1; hi_sense = 1'b0; sw_enable = 1'b1; fault_clr = 1'b0;
        tick(); tick();
        chk("reset_outs", outs(), 8'h00);
        chk("reset_state", {5'd0, seq_state}, 8'd0);
        rst = 1'b0;
        edge_n = 0;

        // debounce glitch: rise at 0, drop at 10, re-rise at 11
        hi_sense = 1'b1;
        wait_to(10); hi_sense = 1'b0;
        wait_to(11); hi_sense = 1'b1;
        wait_to(13);
        chk("glitch_state_off", {5'd0, seq_state}, 8'd0);
        chk("glitch_no_clk", outs(), 8'h00);
        wait_to(29);
        chk("deb_state", {5'd0, seq_state}, 8'd1);
        chk("clk_before", {7'd0, user2_clk_en}, 8'd0);
        wait_to(30);
        chk("clk_on", outs(), 8'h20);
        chk("clk_on_state", {5'd0, seq_state}, 8'd2);
        wait_to(33);
        chk("rst_before", {7'd0, user2_rst_n}, 8'd0);
        wait_to(34);
        chk("rst_rel", outs(), 8'h30);
        wait_to(37);
        chk("bus_before", {7'd0, user2_la_en}, 8'd0);
        wait_to(38);
        chk("on_outs", outs(), 8'h3E);
        chk("on_state", {5'd0, seq_state}, 8'd5);

        // orderly shutdown, sw_enable dropped at E=40
        wait_to(40); sw_enable = 1'b0;
        wait_to(41);
        chk("sd_bus_outs", outs(), 8'h30);
        chk("sd_bus_state", {5'd0, seq_state}, 8'd6);
        wait_to(44);
        chk("sd_rst_before", {7'd0, user2_rst_n}, 8'd1);
        wait_to(45);
        chk("sd_rst_outs", outs(), 8'h20);
        chk("sd_rst_state", {5'd0, seq_state}, 8'd7);
        wait_to(48);
        chk("sd_clk_before", {7'd0, user2_clk_en}, 8'd1);
        wait_to(49);
        chk("sd_off_outs", outs(), 8'h00);
        chk("sd_off_state", {5'd0, seq_state}, 8'd0);

        // power up again with sense already high, then lose power in ON
        wait_to(50); sw_enable = 1'b1;
        wait_to(67);
        chk("re_clk_on", outs(), 8'h20);
        wait_to(75);
        chk("re_on", outs(), 8'h3E);
        wait_to(76); hi_sense = 1'b0;
        wait_to(78);
        chk("loss_pending", outs(), 8'h3E);
        wait_to(79);
        chk("loss_outs", outs(), 8'h01);
        chk("loss_state", {5'd0, seq_state}, 8'd0);

        // sticky fault blocks restart until cleared
        hi_sense = 1'b1;
        wait_to(100);
        chk("fault_hold_outs", outs(), 8'h01);
        chk("fault_hold_state", {5'd0, seq_state}, 8'd0);
        fault_clr = 1'b1;
        wait_to(101); fault_clr = 1'b0;
        chk("fault_cleared", outs(), 8'h00);
        wait_to(102);
        chk("restart_deb", {5'd0, seq_state}, 8'd1);
        wait_to(117);
        chk("restart_clk_before", {7'd0, user2_clk_en}, 8'd0);
        wait_to(118);
        chk("restart_clk", outs(), 8'h20);
        wait_to(122);
        chk("restart_rst", outs(), 8'h30);
        wait_to(126);
        chk("restart_on", outs(), 8'h3E);

        // power loss coincident with fault_clr: the set wins
        wait_to(130); hi_sense = 1'b0;
        wait_to(132); fault_clr = 1'b1;
        wait_to(133); fault_clr = 1'b0;
        chk("simul_outs", outs(), 8'h01);
        wait_to(134);
        chk("simul_fault_kept", {7'd0, user2_fault}, 8'd1);

        // async reset while in RST_REL
        wait_to(135); hi_sense = 1'b1; fault_clr = 1'b1;
        wait_to(136); fault_clr = 1'b0;
        chk("clr2", outs(), 8'h00);
        wait_to(154);
        chk("pre_rst_clk", outs(), 8'h20);
        wait_to(160);
        chk("pre_rst_state", {5'd0, seq_state}, 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", outs(), 8'h00);
        chk("async_rst_state", {5'd0, seq_state}, 8'd0);
        tick();
        rst = 1'b0;
        wait_to(179);
        chk("post_rst_clk_before", {7'd0, user2_clk_en}, 8'd0);
        wait_to(180);
        chk("post_rst_clk", outs(), 8'h20);
        wait_to(184);
        chk("post_rst_rst", outs(), 8'h30);
        wait_to(188);
        chk("post_rst_on", outs(), 8'h3E);
        chk("post_rst_state", {5'd0, seq_state}, 8'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
